riscv_core_div_ctrl: RTL and testbench
======================================

RISCV_CORE_DIV_CTRL -- requirements
Module: riscv_core_div_ctrl

Interface
REQ-001 SHALL have parameter: XLEN, 64, operand/result width.
REQ-002 SHALL have ports:
- i_div_ctrl_clk  in  1  sole clock, rising edge.
- i_div_ctrl_rstn  in  1  asynchronous active-low reset.
- i_div_ctrl_valid  in  1  op request; sampled only in IDLE.
- i_div_ctrl_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other values treated as DIVU.
- i_div_ctrl_word  in  1  1 = W variant (32-bit op, result sign-extended).
- i_div_ctrl_rs1  in  XLEN  dividend.
- i_div_ctrl_rs2  in  XLEN  divisor.
- i_div_ctrl_flush  in  1  abort current op.
- o_div_ctrl_busy  out  1  high in every state except IDLE.
- o_div_ctrl_valid  out  1  one-cycle result strobe.
- o_div_ctrl_result  out  XLEN  final result; 0 when o_div_ctrl_valid=0.
- o_div_ctrl_core_en  out  1  one-cycle launch pulse to unsigned divider core.
- o_div_ctrl_core_dividend  out  XLEN  unsigned magnitude of dividend.
- o_div_ctrl_core_divisor  out  XLEN  unsigned magnitude of divisor.
- i_div_ctrl_core_done  in  1  core done strobe.
- i_div_ctrl_core_quotient  in  XLEN  core quotient, valid only while done=1.
- i_div_ctrl_core_remainder  in  XLEN  core remainder, valid only while done=1.

Function
REQ-003 SHALL implement states IDLE, LAUNCH, WAIT, FIXUP, DONE, DRAIN.
REQ-004 IDLE with valid=1 SHALL latch op, signs and magnitudes, then go to DONE for special cases, else LAUNCH.
REQ-005 Operand prep: word=1 uses rs[31:0], sign-extended for DIV/REM and zero-extended for DIVU/REMU; unsigned ops use raw value; signed ops use two's-complement magnitude.
REQ-006 Divide-by-zero (effective divisor 0): result = all ones for DIV/DIVU, effective dividend for REM/REMU; core never launched.
REQ-007 Signed overflow (effective dividend = most-negative, divisor = -1): result = effective dividend for DIV, 0 for REM; core never launched.
REQ-008 LAUNCH SHALL assert o_div_ctrl_core_en for exactly one cycle with magnitudes stable on core operand ports, then go to WAIT; operand ports hold until next accept.
REQ-009 WAIT SHALL capture quotient/remainder on the cycle core_done=1 and go to FIXUP.
REQ-010 FIXUP: signed quotient negated iff operand signs differ; signed remainder negated iff dividend negative; word=1 result = sign-extend of bit 31 (all four W ops); then DONE.
REQ-011 DONE SHALL assert o_div_ctrl_valid for exactly one cycle with result, then IDLE; o_div_ctrl_result is registered.
REQ-012 Latency: o_div_ctrl_valid two cycles after the core_done cycle; special cases one cycle after accept.
REQ-013 i_div_ctrl_valid outside IDLE SHALL be ignored, no queuing.
REQ-014 flush in LAUNCH or WAIT SHALL go to DRAIN (LAUNCH still emits its core_en pulse); DRAIN discards core_done, then IDLE; no valid for aborted op.
REQ-015 flush in FIXUP or DONE SHALL suppress o_div_ctrl_valid and go to IDLE; flush in IDLE overrides valid (no accept).
REQ-016 core_done outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-017 rstn low SHALL force IDLE and all outputs and internal registers to 0 immediately, regardless of clock.
REQ-018 Reset mid-operation SHALL drop the op silently; no valid after reset release.

Verification
REQ-019 DIVU rs1=100 rs2=7 -> core_en pulse, core operands 100/7; core returns 14 -> result 14, valid 2 cycles after done.
REQ-020 DIV rs1=-7 rs2=2 -> core operands 7/2, result 0xFFFF_FFFF_FFFF_FFFD; REM same -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-021 DIV rs1=5 rs2=0 -> result all ones, REMU -> 5, valid cycle after accept, core_en never high.
REQ-022 DIV rs1=0x8000_0000_0000_0000 rs2=-1 -> result 0x8000_0000_0000_0000; REM -> 0; no core launch.
REQ-023 DIVW rs1=0x1_FFFF_FFF9 rs2=2 -> result 0xFFFF_FFFF_FFFF_FFFD; DIVUW rs1=0xFFFF_FFFF rs2=1 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-024 flush in WAIT -> busy held until core_done+1, no valid; next DIVU 9/3 -> result 3.

Source files
------------

// File: rtl/riscv_core_div_ctrl.sv
// riscv_core_div_ctrl: sign/overflow/zero handling around an unsigned divider core for RV64 M-extension divides
module riscv_core_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            i_div_ctrl_clk,
    input  logic            i_div_ctrl_rstn,
    input  logic            i_div_ctrl_valid,
    input  logic [2:0]      i_div_ctrl_funct3,
    input  logic            i_div_ctrl_word,
    input  logic [XLEN-1:0] i_div_ctrl_rs1,
    input  logic [XLEN-1:0] i_div_ctrl_rs2,
    input  logic            i_div_ctrl_flush,
    output logic            o_div_ctrl_busy,
    output logic            o_div_ctrl_valid,
    output logic [XLEN-1:0] o_div_ctrl_result,
    output logic            o_div_ctrl_core_en,
    output logic [XLEN-1:0] o_div_ctrl_core_dividend,
    output logic [XLEN-1:0] o_div_ctrl_core_divisor,
    input  logic            i_div_ctrl_core_done,
    input  logic [XLEN-1:0] i_div_ctrl_core_quotient,
    input  logic [XLEN-1:0] i_div_ctrl_core_remainder
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FIXUP, DONE, DRAIN} state_t;
    state_t state, state_nx;
    logic op_signed, op_rem, sign_a, sign_b, div_zero, ovf, special, accept;
    logic [XLEN-1:0] eff_a, eff_b, mag_a, mag_b, special_raw, special_res;
    logic r_rem, r_word, r_neg;
    logic [XLEN-1:0] r_dividend, r_divisor, r_raw, r_result, fixed, fixed_res;

    // decode the request, form effective operands, magnitudes and the early-out results
    always_comb begin
        op_signed   = (i_div_ctrl_funct3 == 3'b100) || (i_div_ctrl_funct3 == 3'b110);
        op_rem      = (i_div_ctrl_funct3 == 3'b110) || (i_div_ctrl_funct3 == 3'b111);
        eff_a       = i_div_ctrl_word ? {{(XLEN-32){op_signed & i_div_ctrl_rs1[31]}}, i_div_ctrl_rs1[31:0]} : i_div_ctrl_rs1;
        eff_b       = i_div_ctrl_word ? {{(XLEN-32){op_signed & i_div_ctrl_rs2[31]}}, i_div_ctrl_rs2[31:0]} : i_div_ctrl_rs2;
        sign_a      = op_signed & eff_a[XLEN-1];
        sign_b      = op_signed & eff_b[XLEN-1];
        mag_a       = sign_a ? -eff_a : eff_a;
        mag_b       = sign_b ? -eff_b : eff_b;
        div_zero    = eff_b == '0;
        ovf         = op_signed && (eff_b == '1) &&
                      (i_div_ctrl_word ? eff_a[31:0] == 32'h8000_0000 : eff_a == {1'b1, {(XLEN-1){1'b0}}});
        special     = div_zero || ovf;
        special_raw = div_zero ? (op_rem ? eff_a : '1) : (op_rem ? '0 : eff_a);
        special_res = i_div_ctrl_word ? {{(XLEN-32){special_raw[31]}}, special_raw[31:0]} : special_raw;
        accept      = (state == IDLE) && i_div_ctrl_valid && !i_div_ctrl_flush;
    end

    // restore the sign of the captured core result and narrow W ops to 32 bits
    always_comb begin
        fixed     = r_neg ? -r_raw : r_raw;
        fixed_res = r_word ? {{(XLEN-32){fixed[31]}}, fixed[31:0]} : fixed;
    end

    // next-state: a flush while the core is running must still wait out its done strobe
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (special ? DONE : LAUNCH) : IDLE;
            LAUNCH:  state_nx = i_div_ctrl_flush ? DRAIN : WAIT;
            WAIT:    state_nx = i_div_ctrl_core_done ? (i_div_ctrl_flush ? IDLE : FIXUP) : (i_div_ctrl_flush ? DRAIN : WAIT);
            FIXUP:   state_nx = i_div_ctrl_flush ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            DRAIN:   state_nx = i_div_ctrl_core_done ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // state and datapath registers; operands to the core hold until the next accept
    always_ff @(posedge i_div_ctrl_clk or negedge i_div_ctrl_rstn) begin
        if (!i_div_ctrl_rstn) begin
            state      <= IDLE;
            r_rem      <= 1'b0;
            r_word     <= 1'b0;
            r_neg      <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_raw      <= '0;
            r_result   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                r_rem      <= op_rem;
                r_word     <= i_div_ctrl_word;
                r_neg      <= op_rem ? sign_a : sign_a ^ sign_b;
                r_dividend <= mag_a;
                r_divisor  <= mag_b;
                r_result   <= special_res;
            end
            if (state == WAIT && i_div_ctrl_core_done)
                r_raw <= r_rem ? i_div_ctrl_core_remainder : i_div_ctrl_core_quotient;
            if (state == FIXUP)
                r_result <= fixed_res;
        end
    end

    assign o_div_ctrl_busy          = state != IDLE;
    assign o_div_ctrl_valid         = (state == DONE) && !i_div_ctrl_flush;
    assign o_div_ctrl_result        = o_div_ctrl_valid ? r_result : '0;
    assign o_div_ctrl_core_en       = state == LAUNCH;
    assign o_div_ctrl_core_dividend = r_dividend;
    assign o_div_ctrl_core_divisor  = r_divisor;
endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// tb_riscv_core_div_ctrl: directed vectors with a result scoreboard and a core-response driver
module tb_riscv_core_div_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic        word = 1'b0;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        busy, o_valid, core_en;
    logic [63:0] result, core_dividend, core_divisor;
    logic        core_done = 1'b0;
    logic [63:0] core_q = 64'hDEAD_BEEF_DEAD_BEEF;
    logic [63:0] core_r = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    riscv_core_div_ctrl #(.XLEN(64)) dut (
        .i_div_ctrl_clk            (clk),
        .i_div_ctrl_rstn           (rstn),
        .i_div_ctrl_valid          (valid),
        .i_div_ctrl_funct3         (funct3),
        .i_div_ctrl_word           (word),
        .i_div_ctrl_rs1            (rs1),
        .i_div_ctrl_rs2            (rs2),
        .i_div_ctrl_flush          (flush),
        .o_div_ctrl_busy           (busy),
        .o_div_ctrl_valid          (o_valid),
        .o_div_ctrl_result         (result),
        .o_div_ctrl_core_en        (core_en),
        .o_div_ctrl_core_dividend  (core_dividend),
        .o_div_ctrl_core_divisor   (core_divisor),
        .i_div_ctrl_core_done      (core_done),
        .i_div_ctrl_core_quotient  (core_q),
        .i_div_ctrl_core_remainder (core_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (core_en) en_cnt++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // monitor: every result strobe must match the oldest expected entry, on its expected cycle
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: actual result %h required no strobe", result);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (rstn) begin
            check("result_zero_when_idle", result, 64'd0);
        end
    end

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check(nm, 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        valid = 1'b1; funct3 = f3; word = w; rs1 = a; rs2 = b;
    endtask

    task automatic core_respond(input logic [63:0] q, input logic [63:0] r);
        core_done = 1'b1; core_q = q; core_r = r;
        @(posedge clk);
        #1;
        core_done = 1'b0; core_q = JUNK; core_r = JUNK;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic sp, input logic [63:0] ed, input logic [63:0] es,
                          input logic [63:0] q, input logic [63:0] r, input logic [63:0] req);
        int en0;
        @(posedge clk);
        #1;
        en0 = en_cnt;
        issue(f3, w, a, b);
        if (sp) sb.push_back('{res: req, cyc: cyc + 1});
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (sp) begin
            wait_idle({nm, "_idle"});
            check({nm, "_no_launch"}, 64'(en_cnt), 64'(en0));
        end else begin
            check({nm, "_core_en"}, 64'(core_en), 64'd1);
            check({nm, "_core_dividend"}, core_dividend, ed);
            check({nm, "_core_divisor"}, core_divisor, es);
            @(posedge clk);
            #1;
            check({nm, "_core_en_one_cycle"}, 64'(core_en), 64'd0);
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            sb.push_back('{res: req, cyc: cyc + 2});
            core_respond(q, r);
            wait_idle({nm, "_idle"});
            check({nm, "_one_launch"}, 64'(en_cnt), 64'(en0 + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_core_en", 64'(core_en), 64'd0);
        check("rst_core_dividend", core_dividend, 64'd0);
        check("rst_core_divisor", core_divisor, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_op("divu_100_7", F_DIVU, 1'b0, 64'd100, 64'd7, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64'd14);
        run_op("remu_100_7", F_REMU, 1'b0, 64'd100, 64'd7, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64'd2);
        run_op("div_m7_2", F_DIV, 1'b0, -64'sd7, 64'd2, 1'b0, 64'd7, 64'd2, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_m7_2", F_REM, 1'b0, -64'sd7, 64'd2, 1'b0, 64'd7, 64'd2, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_20_m3", F_DIV, 1'b0, 64'd20, -64'sd3, 1'b0, 64'd20, 64'd3, 64'd6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("rem_20_m3", F_REM, 1'b0, 64'd20, -64'sd3, 1'b0, 64'd20, 64'd3, 64'd6, 64'd2, 64'd2);
        run_op("div_by_zero", F_DIV, 1'b0, 64'd5, 64'd0, 1'b1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_by_zero", F_REMU, 1'b0, 64'd5, 64'd0, 1'b1, 0, 0, 0, 0, 64'd5);
        run_op("div_ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 0, 0, 64'h8000_0000_0000_0000);
        run_op("rem_ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 0, 0, 64'd0);
        run_op("divw", F_DIV, 1'b1, 64'h1_FFFF_FFF9, 64'd2, 1'b0, 64'd7, 64'd2, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divuw", F_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);

        // flush while waiting on the core: busy until the cycle after done, no strobe
        @(posedge clk);
        #1;
        issue(F_DIVU, 1'b0, 64'd50, 64'd5);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("drain_busy", 64'(busy), 64'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("drain_busy_held", 64'(busy), 64'd1);
        core_respond(64'd10, 64'd0);
        check("drain_released", 64'(busy), 64'd0);
        run_op("divu_after_flush", F_DIVU, 1'b0, 64'd9, 64'd3, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 64'd3);

        // new requests while busy are dropped
        @(posedge clk);
        #1;
        en0 = en_cnt;
        issue(F_REMU, 1'b0, 64'd100, 64'd7);
        @(posedge clk);
        #1;
        issue(F_DIV, 1'b0, 64'd5, 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        sb.push_back('{res: 64'd2, cyc: cyc + 2});
        core_respond(64'd14, 64'd2);
        wait_idle("ignore_valid_idle");
        check("ignore_valid_one_launch", 64'(en_cnt), 64'(en0 + 1));

        // flush in IDLE beats valid; stray core_done in IDLE is ignored
        @(posedge clk);
        #1;
        issue(F_DIV, 1'b0, 64'd5, 64'd0);
        flush = 1'b1;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        core_done = 1'b0;
        check("idle_flush_no_accept", 64'(busy), 64'd0);

        // flush during the DONE cycle suppresses the strobe
        @(posedge clk);
        #1;
        issue(F_DIV, 1'b0, 64'd5, 64'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("done_flush_idle", 64'(busy), 64'd0);

        // asynchronous reset in the middle of an op
        @(posedge clk);
        #1;
        issue(F_DIVU, 1'b0, 64'd100, 64'd7);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_dividend", core_dividend, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        core_respond(64'd14, 64'd2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_idle", 64'(busy), 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
